dw_conv_window_stream: RTL and testbench
========================================

// Module: dw_conv_window_stream
// PURPOSE
//  Depthwise-conv front end: K-1 row line buffer plus KxK window generator for CH_NUM parallel channels.
//  Adds runtime frame size, optional zero padding (K/2), stride 1/2, and valid/ready on both sides.
//  Sits between the feature-map stream and the DW MAC array.
//  Emits one KxK window per output pixel and a done pulse per frame.
// PARAMETERS
//  DATA_WIDTH  8    bits per channel sample
//  CH_NUM      18   channels carried in parallel per pixel
//  KSIZE       3    kernel size, odd, 3 or 5; P = KSIZE/2
//  MAX_COLS    322  line-buffer depth; cfg_cols + 2P <= MAX_COLS
//  DIM_W       10   width of row/column configuration and counters
// PORTS
//  clk        in   1                             rising-edge clock
//  rst        in   1                             synchronous, active-high reset
//  start      in   1                             latch cfg_* and begin a frame; honoured in IDLE only
//  cfg_cols   in   DIM_W                         input frame width, >= KSIZE
//  cfg_rows   in   DIM_W                         input frame height, >= KSIZE
//  cfg_pad    in   1                             1: zero-pad P on all sides
//  cfg_stride in   1                             0: stride 1, 1: stride 2
//  s_data     in   CH_NUM*DATA_WIDTH             input pixel, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//  s_valid    in   1                             input pixel valid
//  s_ready    out  1                             input accepted when s_valid && s_ready
//  m_win      out  KSIZE*KSIZE*CH_NUM*DATA_WIDTH window; elem (r,c,ch) at [((r*KSIZE+c)*CH_NUM+ch)*DATA_WIDTH]
//  m_valid    out  1                             window valid
//  m_ready    in   1                             downstream accepts the window
//  busy       out  1                             high from start acceptance through the done cycle
//  done       out  1                             one-cycle pulse after the last window handshake
// BEHAVIOUR
//  Reset: state=IDLE; s_ready, m_valid, busy and done = 0; m_win=0; counters=0. Line-buffer RAM is not cleared.
//  Virtual stream: W'=cols+2P*pad, H'=rows+2P*pad, walked raster-order with counters x,y.
//    Element (x,y) is pad when pad=1 and (x<P | x>=P+cols | y<P | y>=P+rows); pad elements carry 0.
//  stall = m_valid && !m_ready. An element advances only when in RUN and !stall.
//    For a real element it also needs s_valid (handshake).
//    For a pad element it needs nothing; it is injected internally.
//  s_ready = (state==RUN) && !stall && current element is real. It is 0 during pad injection.
//  On advance:
//    - The shift window moves left one column; the new column is line-buffer rows 0..K-2 plus the element.
//    - Line buffer at address x is updated.
//    - x wraps at W'-1 and y increments; row-start flushing needs no extra cycles.
//  Window emit: on advancing (x,y) with x>=K-1, y>=K-1, and for stride 2 (x-K+1) and (y-K+1) even.
//    The next cycle has m_valid=1 and m_win holds rows y-K+1..y, cols x-K+1..x.
//    Latency is 1 cycle from the completing advance. Row r=0 is the oldest row.
//  m_win and m_valid are held stable while m_valid && !m_ready; they are never dropped or overwritten.
//  Output size: Wo=(W'-K)/S+1, Ho=(H'-K)/S+1 (floor); exactly Wo*Ho windows per frame.
//  FSM:
//    IDLE  -> RUN on start; latch cfg, clear x,y, busy=1.
//    RUN   -> DRAIN after advancing the last element (W'-1,H'-1).
//    DRAIN -> DONE when m_valid is 0, or m_valid && m_ready.
//    DONE  -> IDLE after 1 cycle; done=1 in DONE only; busy=0 on return to IDLE.
//  Other events:
//    - start outside IDLE is ignored; cfg changes mid-frame have no effect.
//    - Input beats beyond H'*W' elements are not accepted (s_ready=0 outside RUN).
//    - rst mid-frame returns to IDLE immediately per the reset values; the partial window is discarded.
//  Arithmetic: unsigned counters on DIM_W bits; samples are passed through, never modified.
// TESTING
//  T1 K=3 4x4 ch0=y*4+x, no pad, s1, m_ready=1
//     -> 4 windows; first ch0 {0,1,2,4,5,6,8,9,10}; done 1 cycle after the 4th.
//  T2 same frame, pad=1
//     -> 16 windows; first ch0 {0,0,0,0,0,1,0,4,5}; last {10,11,0,14,15,0,0,0,0}.
//  T3 5x5, pad=1, stride 2
//     -> 9 windows centred at (0,0),(2,0),(4,0)...(4,4); centre ch0 = 0,2,4,10,...,24.
//  T4 T1 with m_ready toggled 1-in-3
//     -> identical window sequence; m_win stable while stalled; s_ready=0 whenever m_valid && !m_ready.
//  T5 rst at 7th input beat of T1, then restart T1
//     -> outputs zero next cycle; second run matches T1 exactly.
//  T6 start pulsed during RUN with different cfg
//     -> ignored; frame completes with the original cfg; done pulses once.

Source files
------------

// File: rtl/dw_conv_window_stream.sv
// Depthwise-conv front end: KSIZE-1 row line buffer feeding a KxK shift window for CH_NUM
// parallel channels, with runtime frame size, zero padding, stride 1/2 and valid/ready flow control.
module dw_conv_window_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_NUM     = 18,
  parameter int KSIZE      = 3,
  parameter int MAX_COLS   = 322,
  parameter int DIM_W      = 10
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [DIM_W-1:0]                          cfg_cols,
  input  logic [DIM_W-1:0]                          cfg_rows,
  input  logic                                      cfg_pad,
  input  logic                                      cfg_stride,
  input  logic [CH_NUM*DATA_WIDTH-1:0]              s_data,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  output logic [KSIZE*KSIZE*CH_NUM*DATA_WIDTH-1:0]  m_win,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic                                      busy,
  output logic                                      done
);
  localparam int PIX_W = CH_NUM * DATA_WIDTH;
  localparam int WIN_W = KSIZE * KSIZE * PIX_W;
  localparam int P     = KSIZE / 2;
  localparam int AW    = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [DIM_W-1:0] ONE_D   = DIM_W'(1);
  localparam logic [DIM_W-1:0] P_D     = DIM_W'(P);
  localparam logic [DIM_W-1:0] TWO_P_D = DIM_W'(2 * P);
  localparam logic [DIM_W-1:0] KM1_D   = DIM_W'(KSIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [DIM_W-1:0]       x_r, y_r, cols_r, rows_r;
  logic                   pad_r, stride_r;
  logic                   m_valid_r, busy_r, done_r;
  logic [WIN_W-1:0]       m_win_r;
  logic [PIX_W-1:0]       lb_r [KSIZE-1][MAX_COLS];
  logic [PIX_W-1:0]       win_r [KSIZE][KSIZE];

  logic [DIM_W-1:0]       wp_s, hp_s;
  logic [AW-1:0]          addr_s;
  logic                   is_pad_s, last_s, stall_s, run_s, advance_s, emit_s;
  logic [PIX_W-1:0]       elem_s;
  logic [PIX_W-1:0]       col_s [KSIZE];
  logic [PIX_W-1:0]       win_nx_s [KSIZE][KSIZE];
  logic [WIN_W-1:0]       win_flat_s;

  assign addr_s = x_r[AW-1:0];

  // Virtual frame extent, pad classification and advance/emit qualification for (x,y)
  always_comb begin
    wp_s = cols_r;
    hp_s = rows_r;
    if (pad_r) begin
      wp_s = cols_r + TWO_P_D;
      hp_s = rows_r + TWO_P_D;
    end else begin
      wp_s = cols_r;
      hp_s = rows_r;
    end
    is_pad_s  = pad_r && ((x_r < P_D) || (x_r >= cols_r + P_D) ||
                          (y_r < P_D) || (y_r >= rows_r + P_D));
    last_s    = (x_r == wp_s - ONE_D) && (y_r == hp_s - ONE_D);
    run_s     = (state_r == S_RUN);
    stall_s   = m_valid_r && !m_ready;
    advance_s = run_s && !stall_s && (is_pad_s || s_valid);
    elem_s    = s_data;
    if (is_pad_s) begin
      elem_s = '0;
    end else begin
      elem_s = s_data;
    end
    // K-1 is even, so the stride-2 phase test on (x-K+1) reduces to parity of x and y
    emit_s = advance_s && (x_r >= KM1_D) && (y_r >= KM1_D) &&
             (!stride_r || (((x_r[0] ^ KM1_D[0]) == 1'b0) && ((y_r[0] ^ KM1_D[0]) == 1'b0)));
  end

  // New column from the line buffer plus the current element, and the shifted window
  always_comb begin
    win_flat_s = '0;
    for (int r = 0; r < KSIZE; r++) begin
      col_s[r] = '0;
      for (int c = 0; c < KSIZE; c++) begin
        win_nx_s[r][c] = '0;
      end
    end
    for (int r = 0; r < KSIZE-1; r++) begin
      col_s[r] = lb_r[r][addr_s];
    end
    col_s[KSIZE-1] = elem_s;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE-1; c++) begin
        win_nx_s[r][c] = win_r[r][c+1];
      end
      win_nx_s[r][KSIZE-1] = col_s[r];
    end
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        win_flat_s[(r*KSIZE+c)*PIX_W +: PIX_W] = win_nx_s[r][c];
      end
    end
  end

  // Frame sequencing
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_RUN;
        else       state_s = S_IDLE;
      end
      S_RUN: begin
        if (advance_s && last_s) state_s = S_DRAIN;
        else                     state_s = S_RUN;
      end
      S_DRAIN: begin
        if (!m_valid_r || m_ready) state_s = S_DONE;
        else                       state_s = S_DRAIN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Control state, frame counters, shift window and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      x_r       <= '0;
      y_r       <= '0;
      cols_r    <= '0;
      rows_r    <= '0;
      pad_r     <= 1'b0;
      stride_r  <= 1'b0;
      m_valid_r <= 1'b0;
      m_win_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          win_r[r][c] <= '0;
        end
      end
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_s == S_DONE);
      if ((state_r == S_IDLE) && start) begin
        cols_r   <= cfg_cols;
        rows_r   <= cfg_rows;
        pad_r    <= cfg_pad;
        stride_r <= cfg_stride;
        x_r      <= '0;
        y_r      <= '0;
      end else if (advance_s) begin
        if (x_r == wp_s - ONE_D) begin
          x_r <= '0;
          y_r <= y_r + ONE_D;
        end else begin
          x_r <= x_r + ONE_D;
        end
      end
      if (advance_s) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE; c++) begin
            win_r[r][c] <= win_nx_s[r][c];
          end
        end
      end
      // Advance is blocked while stalled, so a pending window is never overwritten
      if (emit_s) begin
        m_valid_r <= 1'b1;
        m_win_r   <= win_flat_s;
      end else if (m_ready) begin
        m_valid_r <= 1'b0;
      end
    end
  end

  // Line buffer: each column slot shifts up one row per advance; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && advance_s) begin
      for (int r = 0; r < KSIZE-2; r++) begin
        lb_r[r][addr_s] <= lb_r[r+1][addr_s];
      end
      lb_r[KSIZE-2][addr_s] <= elem_s;
    end
  end

  assign s_ready = run_s && !stall_s && !is_pad_s;
  assign m_win   = m_win_r;
  assign m_valid = m_valid_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_dw_conv_window_stream.sv
// Directed bench for dw_conv_window_stream: small frames with hand-derived windows plus a
// reference window builder working straight from the frame contents.
module tb_dw_conv_window_stream;
  localparam int DW    = 8;
  localparam int CH    = 18;
  localparam int K     = 3;
  localparam int MAXC  = 322;
  localparam int DIM_W = 10;
  localparam int PIX_W = CH * DW;
  localparam int WIN_W = K * K * PIX_W;

  logic               clk = 1'b0;
  logic               rst, start, cfg_pad, cfg_stride, s_valid, s_ready, m_valid, m_ready, busy, done;
  logic [DIM_W-1:0]   cfg_cols, cfg_rows;
  logic [PIX_W-1:0]   s_data;
  logic [WIN_W-1:0]   m_win;

  int n_checks = 0;
  int n_errors = 0;
  int centre_q[$];

  dw_conv_window_stream #(
    .DATA_WIDTH(DW), .CH_NUM(CH), .KSIZE(K), .MAX_COLS(MAXC), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .cfg_pad(cfg_pad), .cfg_stride(cfg_stride), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_win(m_win), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel ch of pixel (x,y): ch0 = y*cols+x, other channels offset so lanes differ
  function automatic logic [DW-1:0] pix(input int x, input int y, input int ch, input int cols);
    return DW'((y * cols + x + 7 * ch) % 256);
  endfunction

  function automatic logic [PIX_W-1:0] pix_vec(input int idx, input int cols);
    logic [PIX_W-1:0] v;
    v = '0;
    for (int ch = 0; ch < CH; ch++) v[ch*DW +: DW] = pix(idx % cols, idx / cols, ch, cols);
    return v;
  endfunction

  // Reference k-th window in raster output order, built directly from the padded frame
  function automatic logic [WIN_W-1:0] exp_win(input int k, input int cols, input int rows,
                                               input bit pad, input bit stride);
    logic [WIN_W-1:0] w;
    int p, s, wo, ox, oy, vx, vy;
    w  = '0;
    p  = pad ? K / 2 : 0;
    s  = stride ? 2 : 1;
    wo = (cols + 2 * p - K) / s + 1;
    ox = (k % wo) * s;
    oy = (k / wo) * s;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        vx = ox + c - p;
        vy = oy + r - p;
        if (vx >= 0 && vx < cols && vy >= 0 && vy < rows)
          for (int ch = 0; ch < CH; ch++) w[((r*K+c)*CH+ch)*DW +: DW] = pix(vx, vy, ch, cols);
      end
    return w;
  endfunction

  function automatic logic [71:0] ch0_of(input logic [WIN_W-1:0] w);
    logic [71:0] v;
    v = '0;
    for (int e = 0; e < 9; e++) v[e*8 +: 8] = w[e*PIX_W +: 8];
    return v;
  endfunction

  task automatic check_idle_outputs(input string name);
    check_val({name, " m_valid"}, WIN_W'(m_valid), WIN_W'(1'b0));
    check_val({name, " m_win"},   m_win,           '0);
    check_val({name, " busy"},    WIN_W'(busy),    WIN_W'(1'b0));
    check_val({name, " done"},    WIN_W'(done),    WIN_W'(1'b0));
    check_val({name, " s_ready"}, WIN_W'(s_ready), WIN_W'(1'b0));
  endtask

  task automatic run_frame(input string name, input int cols, input int rows, input bit pad,
                           input bit stride, input bit slow_ready, input int rst_beat,
                           input bit poke_start,
                           output logic [WIN_W-1:0] first_w, output logic [WIN_W-1:0] last_w);
    int idx, nwin, cyc, hs_cyc, p, s, wo, ho;
    bit finished, prev_stall;
    logic [WIN_W-1:0] held;
    p = pad ? K / 2 : 0;
    s = stride ? 2 : 1;
    wo = (cols + 2 * p - K) / s + 1;
    ho = (rows + 2 * p - K) / s + 1;
    idx = 0; nwin = 0; cyc = 0; hs_cyc = -10;
    finished = 1'b0; prev_stall = 1'b0; held = '0; first_w = '0; last_w = '0;
    centre_q.delete();
    @(posedge clk); #1;
    cfg_cols = DIM_W'(cols); cfg_rows = DIM_W'(rows); cfg_pad = pad; cfg_stride = stride;
    start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check_val({name, " busy after start"}, WIN_W'(busy), WIN_W'(1'b1));
    while (!finished && cyc < 3000) begin
      m_ready = slow_ready ? (cyc % 3 == 2) : 1'b1;
      s_valid = (idx < cols * rows);
      s_data  = pix_vec(idx, cols);
      if (poke_start && cyc == 5) begin
        start = 1'b1; cfg_cols = DIM_W'(5); cfg_rows = DIM_W'(6); cfg_pad = 1'b1; cfg_stride = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check_val({name, " stall m_valid held"}, WIN_W'(m_valid), WIN_W'(1'b1));
        check_val({name, " stall m_win held"}, m_win, held);
      end
      if (m_valid && !m_ready)
        check_val({name, " s_ready while stalled"}, WIN_W'(s_ready), WIN_W'(1'b0));
      prev_stall = m_valid && !m_ready;
      held = m_win;
      if (m_valid && m_ready) begin
        check_val({name, " window"}, m_win, exp_win(nwin, cols, rows, pad, stride));
        if (nwin == 0) first_w = m_win;
        last_w = m_win;
        centre_q.push_back(int'(m_win[4*PIX_W +: 8]));
        nwin++;
        hs_cyc = cyc;
      end
      if (done) begin
        finished = 1'b1;
        check_val({name, " done one cycle after last window"}, WIN_W'(cyc), WIN_W'(hs_cyc + 1));
      end
      if (rst_beat >= 0 && idx == rst_beat && s_valid && s_ready) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        #1;
        check_idle_outputs({name, " after rst"});
        return;
      end
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
    check_val({name, " frame completed in budget"}, WIN_W'(finished), WIN_W'(1'b1));
    check_val({name, " window count"}, WIN_W'(nwin), WIN_W'(wo * ho));
    check_val({name, " beats accepted"}, WIN_W'(idx), WIN_W'(cols * rows));
    @(posedge clk); #2;
    check_val({name, " done is a pulse"}, WIN_W'(done), WIN_W'(1'b0));
    check_val({name, " busy cleared"}, WIN_W'(busy), WIN_W'(1'b0));
    repeat (3) @(posedge clk);
    #2;
    check_val({name, " stays idle"}, WIN_W'(busy), WIN_W'(1'b0));
  endtask

  initial begin : main
    logic [WIN_W-1:0] fw, lw;
    int centres [9];
    centres = '{0, 2, 4, 10, 12, 14, 20, 22, 24};
    rst = 1'b1; start = 1'b0; cfg_cols = '0; cfg_rows = '0; cfg_pad = 1'b0; cfg_stride = 1'b0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("reset");

    run_frame("t1", 4, 4, 1'b0, 1'b0, 1'b0, -1, 1'b0, fw, lw);
    check_val("t1 first ch0", WIN_W'(ch0_of(fw)), WIN_W'(72'h0a0908060504020100));
    check_val("t1 last ch0",  WIN_W'(ch0_of(lw)), WIN_W'(72'h0f0e0d0b0a0907_0605));

    run_frame("t2", 4, 4, 1'b1, 1'b0, 1'b0, -1, 1'b0, fw, lw);
    check_val("t2 first ch0", WIN_W'(ch0_of(fw)), WIN_W'(72'h050400010000000000));
    check_val("t2 last ch0",  WIN_W'(ch0_of(lw)), WIN_W'(72'h000000000f0e000b0a));

    run_frame("t3", 5, 5, 1'b1, 1'b1, 1'b0, -1, 1'b0, fw, lw);
    check_val("t3 centre count", WIN_W'(centre_q.size()), WIN_W'(9));
    for (int i = 0; i < 9; i++)
      if (i < centre_q.size()) check_val("t3 centre ch0", WIN_W'(centre_q[i]), WIN_W'(centres[i]));

    run_frame("t4", 4, 4, 1'b0, 1'b0, 1'b1, -1, 1'b0, fw, lw);
    check_val("t4 first ch0", WIN_W'(ch0_of(fw)), WIN_W'(72'h0a0908060504020100));

    run_frame("t5a", 4, 4, 1'b0, 1'b0, 1'b0, 6, 1'b0, fw, lw);
    run_frame("t5b", 4, 4, 1'b0, 1'b0, 1'b0, -1, 1'b0, fw, lw);
    check_val("t5 first ch0", WIN_W'(ch0_of(fw)), WIN_W'(72'h0a0908060504020100));

    run_frame("t6", 4, 4, 1'b0, 1'b0, 1'b0, -1, 1'b1, fw, lw);
    check_val("t6 last ch0", WIN_W'(ch0_of(lw)), WIN_W'(72'h0f0e0d0b0a09070605));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
